// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory responder for the single-cycle MIPS core.
// Serves a word-addressed data RAM and an MMIO window (addr[31:16]==MMIO_TAG)
// holding GPIO, a 32-bit timer with compare/match, and a misaligned-write
// error counter. Reads are combinational; all state updates on the rising edge.
//
// Optional build macro: TIMER_PRESCALE_EN -- when defined, timer ticks are
// divided by PRESCALE; when undefined the timer ticks every enabled cycle.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset
//   memwrite   write strobe from core
//   addr       byte address from core
//   writedata  store data
//   readdata   load data, combinational from addr
//   gpio_out   GPIO register value
//   timer_irq  timer MATCH flag
//   err_flag   high while the misaligned-write counter is non-zero
//
// MMIO map (addr[15:0], addr[1:0] ignored on reads):
//   0x00 GPIO[7:0] RW, 0x04 COUNT RW, 0x08 CMP RW,
//   0x0C CTRL {MATCH(W1C), AUTORELOAD, EN}, 0x10 ERR_COUNT RO, others read 0.
module dmem_responder #(
  parameter int unsigned RAM_WORDS = 64,
  parameter logic [15:0] MMIO_TAG  = 16'hFFFF,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  gpio_out,
  output logic        timer_irq,
  output logic        err_flag
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  // MMIO word offsets (addr[15:2])
  localparam logic [13:0] OFF_GPIO  = 14'd0;
  localparam logic [13:0] OFF_COUNT = 14'd1;
  localparam logic [13:0] OFF_CMP   = 14'd2;
  localparam logic [13:0] OFF_CTRL  = 14'd3;
  localparam logic [13:0] OFF_ERR   = 14'd4;

  // Address decode
  logic          is_mmio_c;
  logic          aligned_c;
  logic          wr_ok_c;
  logic [13:0]   woff_c;
  logic [AW-1:0] ram_idx_c;

  assign is_mmio_c = (addr[31:16] == MMIO_TAG);
  assign aligned_c = (addr[1:0] == 2'b00);
  assign wr_ok_c   = memwrite && aligned_c;
  assign woff_c    = addr[15:2];
  assign ram_idx_c = addr[AW+1:2];

  logic wr_gpio_c, wr_count_c, wr_cmp_c, wr_ctrl_c;
  assign wr_gpio_c  = wr_ok_c && is_mmio_c && (woff_c == OFF_GPIO);
  assign wr_count_c = wr_ok_c && is_mmio_c && (woff_c == OFF_COUNT);
  assign wr_cmp_c   = wr_ok_c && is_mmio_c && (woff_c == OFF_CMP);
  assign wr_ctrl_c  = wr_ok_c && is_mmio_c && (woff_c == OFF_CTRL);

  // Data RAM: contents are not reset
  logic [31:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_ok_c && !is_mmio_c) begin
      mem_q[ram_idx_c] <= writedata;
    end
  end

  // Register state
  logic [7:0]  gpio_q, gpio_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        autoreload_q, autoreload_d;
  logic        match_q, match_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        err_flag_q, err_flag_d;

  logic tick_c;
  logic hit_c;

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          presc_last_c;

  assign presc_last_c = (presc_q == PW'(PRESCALE - 1));
  assign tick_c       = en_q && presc_last_c;

  // Prescaler restarts whenever the timer is disabled or COUNT is reloaded
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (!en_q || wr_count_c || presc_last_c) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // Without the prescaler PRESCALE has no effect; the term is constant-true
  // for any legal PRESCALE value.
  assign tick_c = en_q && (PRESCALE >= 32'd1);
`endif

  assign hit_c = tick_c && (count_q == cmp_q);

  // Next-state for timer, GPIO and error counter
  always_comb begin
    gpio_d       = gpio_q;
    count_d      = count_q;
    cmp_d        = cmp_q;
    en_d         = en_q;
    autoreload_d = autoreload_q;
    match_d      = match_q;
    err_cnt_d    = err_cnt_q;

    if (tick_c) begin
      count_d = (hit_c && autoreload_q) ? 32'd0 : count_q + 32'd1;
    end
    // CPU write to COUNT overrides the tick
    if (wr_count_c) begin
      count_d = writedata;
    end

    if (wr_gpio_c) begin
      gpio_d = writedata[7:0];
    end
    if (wr_cmp_c) begin
      cmp_d = writedata;
    end
    if (wr_ctrl_c) begin
      en_d         = writedata[0];
      autoreload_d = writedata[1];
      if (writedata[2]) begin
        match_d = 1'b0;
      end
    end
    // A new match beats a same-cycle W1C
    if (hit_c) begin
      match_d = 1'b1;
    end

    if (memwrite && !aligned_c && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    err_flag_d = (err_cnt_d != 8'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q       <= 8'd0;
      count_q      <= 32'd0;
      cmp_q        <= 32'hFFFF_FFFF;
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      match_q      <= 1'b0;
      err_cnt_q    <= 8'd0;
      err_flag_q   <= 1'b0;
    end else begin
      gpio_q       <= gpio_d;
      count_q      <= count_d;
      cmp_q        <= cmp_d;
      en_q         <= en_d;
      autoreload_q <= autoreload_d;
      match_q      <= match_d;
      err_cnt_q    <= err_cnt_d;
      err_flag_q   <= err_flag_d;
    end
  end

  // Combinational read mux
  always_comb begin
    readdata = 32'd0;
    if (is_mmio_c) begin
      case (woff_c)
        OFF_GPIO:  readdata = {24'd0, gpio_q};
        OFF_COUNT: readdata = count_q;
        OFF_CMP:   readdata = cmp_q;
        OFF_CTRL:  readdata = {29'd0, match_q, autoreload_q, en_q};
        OFF_ERR:   readdata = {24'd0, err_cnt_q};
        default:   readdata = 32'd0;
      endcase
    end else begin
      readdata = mem_q[ram_idx_c];
    end
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = match_q;
  assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// timer/reset sequences, then randomized traffic against a reference model.
module tb_dmem_responder;

  localparam int unsigned RAM_WORDS = 64;
`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PRESCALE = 4;
`endif

  localparam logic [31:0] A_GPIO  = 32'hFFFF_0000;
  localparam logic [31:0] A_COUNT = 32'hFFFF_0004;
  localparam logic [31:0] A_CMP   = 32'hFFFF_0008;
  localparam logic [31:0] A_CTRL  = 32'hFFFF_000C;
  localparam logic [31:0] A_ERR   = 32'hFFFF_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  gpio_out;
  logic        timer_irq;
  logic        err_flag;

  int tests = 0;
  int fails = 0;

  dmem_responder #(
    .RAM_WORDS(64),
    .MMIO_TAG (16'hFFFF),
    .PRESCALE (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .gpio_out (gpio_out),
    .timer_irq(timer_irq),
    .err_flag (err_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after an edge; combinational readdata is checked 1ns later.
  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] wd);
    memwrite  = mw;
    addr      = a;
    writedata = wd;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_vld [RAM_WORDS];
  logic [7:0]  m_gpio;
  logic [31:0] m_count, m_cmp;
  bit          m_en, m_ar, m_match;
  int          m_err;
`ifdef TIMER_PRESCALE_EN
  int          m_presc;
`endif

  task automatic m_reset;
    m_gpio = 8'd0; m_count = 32'd0; m_cmp = 32'hFFFF_FFFF;
    m_en = 0; m_ar = 0; m_match = 0; m_err = 0;
`ifdef TIMER_PRESCALE_EN
    m_presc = 0;
`endif
    for (int i = 0; i < RAM_WORDS; i++) m_vld[i] = 0;
  endtask

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % 32'(RAM_WORDS));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    logic [15:0] off;
    known = 1;
    if (a[31:16] == 16'hFFFF) begin
      off = a[15:0] & 16'hFFFC;
      case (off)
        16'h0000: return {24'd0, m_gpio};
        16'h0004: return m_count;
        16'h0008: return m_cmp;
        16'h000C: return {29'd0, m_match, m_ar, m_en};
        16'h0010: return 32'(m_err);
        default:  return 32'd0;
      endcase
    end
    known = m_vld[m_idx(a)];
    return m_ram[m_idx(a)];
  endfunction

  task automatic m_clock(input logic mw, input logic [31:0] a, input logic [31:0] wd);
    bit          tick, hit, wrote_count, old_en;
    logic [31:0] nc;
    bit          nm;
    old_en = m_en;
    tick   = m_en;
`ifdef TIMER_PRESCALE_EN
    tick = m_en && (m_presc == PRESCALE - 1);
`endif
    hit = tick && (m_count == m_cmp);
    nc  = m_count;
    if (tick) nc = (hit && m_ar) ? 32'd0 : m_count + 32'd1;
    nm = m_match || hit;
    wrote_count = 0;
    if (mw && a[1:0] != 2'b00) begin
      m_err = (m_err == 255) ? 255 : m_err + 1;
    end else if (mw) begin
      if (a[31:16] == 16'hFFFF) begin
        case (a[15:0])
          16'h0000: m_gpio = wd[7:0];
          16'h0004: begin nc = wd; wrote_count = 1; end
          16'h0008: m_cmp = wd;
          16'h000C: begin
            m_en = wd[0];
            m_ar = wd[1];
            if (wd[2] && !hit) nm = 0;
          end
          default: ;
        endcase
      end else begin
        m_ram[m_idx(a)] = wd;
        m_vld[m_idx(a)] = 1;
      end
    end
`ifdef TIMER_PRESCALE_EN
    if (!old_en || wrote_count || m_presc == PRESCALE - 1) m_presc = 0;
    else m_presc = m_presc + 1;
`else
    if (old_en && wrote_count) nc = wd;
`endif
    m_count = nc;
    m_match = nm;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        mw;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] rd;
    logic [7:0]  gpio;
    logic        err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] seq_cnt [8];
    logic [31:0] wrap_cnt [4];
    logic        wrap_irq [4];
    logic [31:0] exp_rd;
    bit          known;

    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          8'h00, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF,  8'h00, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0110, 32'h0,         1'b1, 32'hDEAD_BEEF,  8'h00, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0013, 32'h0000_1234, 1'b1, 32'hDEAD_BEEF,  8'h00, 1'b1};
    tbl[4]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF,  8'h00, 1'b1};
    tbl[5]  = '{1'b0, A_ERR,         32'h0,         1'b1, 32'h0000_0001,  8'h00, 1'b1};
    tbl[6]  = '{1'b1, A_GPIO,        32'hABCD_EF5A, 1'b0, 32'h0,          8'h5A, 1'b1};
    tbl[7]  = '{1'b0, A_GPIO,        32'h0,         1'b1, 32'h0000_005A,  8'h5A, 1'b1};
    tbl[8]  = '{1'b1, 32'hFFFF_0020, 32'h1234_5678, 1'b1, 32'h0,          8'h5A, 1'b1};
    tbl[9]  = '{1'b0, 32'hFFFF_0020, 32'h0,         1'b1, 32'h0,          8'h5A, 1'b1};
    tbl[10] = '{1'b0, A_GPIO,        32'h0,         1'b1, 32'h0000_005A,  8'h5A, 1'b1};

    seq_cnt  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
    wrap_cnt = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};
    wrap_irq = '{1'b0, 1'b0, 1'b1, 1'b1};

    // Reset values
    reset = 1'b0;
    drive(1'b0, A_CMP, 32'd0);
    #10;
    check("rst_gpio", {24'd0, gpio_out}, 32'd0);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    check("rst_err", {31'd0, err_flag}, 32'd0);
    check("rst_cmp", readdata, 32'hFFFF_FFFF);
    addr = A_COUNT; #1;
    check("rst_count", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].mw, tbl[i].a, tbl[i].wd);
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rd", i), readdata, tbl[i].rd);
      step;
      check($sformatf("vec%0d_gpio", i), {24'd0, gpio_out}, {24'd0, tbl[i].gpio});
      check($sformatf("vec%0d_err", i), {31'd0, err_flag}, {31'd0, tbl[i].err});
    end

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 32'h0000_0101, 32'($urandom));
      step;
    end
    drive(1'b0, A_ERR, 32'd0);
    check("err_sat", readdata, 32'h0000_00FF);
    check("err_sat_flag", {31'd0, err_flag}, 32'd1);
    step;

    // Timer match with autoreload, CMP=5
    drive(1'b1, A_CMP, 32'd5); step;
    drive(1'b1, A_CTRL, 32'd3); step;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, A_COUNT, 32'd0);
      check($sformatf("ar_count%0d", i), readdata, seq_cnt[i]);
      step;
      check($sformatf("ar_irq%0d", i), {31'd0, timer_irq}, (i >= 5) ? 32'd1 : 32'd0);
    end
    // W1C with no coincident match (count 2)
    drive(1'b1, A_CTRL, 32'd7); step;
    check("w1c_clear_irq", {31'd0, timer_irq}, 32'd0);
    drive(1'b0, A_CTRL, 32'd0);
    check("w1c_ctrl_rd", readdata, 32'd3);
    step;
    drive(1'b0, A_COUNT, 32'd0);
    check("w1c_count4", readdata, 32'd4);
    step;
    // W1C coincident with a match: set wins
    drive(1'b1, A_CTRL, 32'd7);
    check("w1c_hit_pre", readdata, 32'd3);
    step;
    check("w1c_hit_irq", {31'd0, timer_irq}, 32'd1);
    drive(1'b0, A_CTRL, 32'd0);
    check("w1c_hit_ctrl", readdata, 32'd7);
    step;

    // Disable and clear
    drive(1'b1, A_CTRL, 32'd4); step;
    drive(1'b1, A_CTRL, 32'd4); step;
    check("dis_irq", {31'd0, timer_irq}, 32'd0);
    drive(1'b0, A_CTRL, 32'd0);
    check("dis_ctrl", readdata, 32'd0);
    step;

    // Wrap through 0xFFFFFFFF, match at CMP=0
    drive(1'b1, A_COUNT, 32'hFFFF_FFFE); step;
    drive(1'b1, A_CMP, 32'd0); step;
    drive(1'b1, A_CTRL, 32'd1); step;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, A_COUNT, 32'd0);
      check($sformatf("wrap_count%0d", i), readdata, wrap_cnt[i]);
      step;
      check($sformatf("wrap_irq%0d", i), {31'd0, timer_irq}, {31'd0, wrap_irq[i]});
    end
    // COUNT write during a tick wins
    drive(1'b1, A_COUNT, 32'd100); step;
    drive(1'b0, A_COUNT, 32'd0);
    check("prec_count100", readdata, 32'd100);
    step;
    drive(1'b0, A_COUNT, 32'd0);
    check("prec_count101", readdata, 32'd101);
    step;

    // Asynchronous reset mid-count
    drive(1'b1, A_COUNT, 32'd37); step;
    drive(1'b0, A_COUNT, 32'd0);
    check("pre_rst_count", readdata, 32'd37);
    check("pre_rst_irq", {31'd0, timer_irq}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_count", readdata, 32'd0);
    check("async_rst_irq", {31'd0, timer_irq}, 32'd0);
    check("async_rst_gpio", {24'd0, gpio_out}, 32'd0);
    check("async_rst_err", {31'd0, err_flag}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step;

`ifdef TIMER_PRESCALE_EN
    // Prescaled run: one increment per PRESCALE cycles
    drive(1'b1, A_CTRL, 32'd1); step;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, A_COUNT, 32'd0);
      check($sformatf("presc_count%0d", i), readdata, 32'(i / PRESCALE));
      step;
    end
`endif

    // Randomized traffic against the reference model
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step;
    m_reset();
    for (int n = 0; n < 600; n++) begin
      logic        mw;
      logic [31:0] a, wd;
      int          sel;
      logic [15:0] offs [7];
      offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0020};
      mw  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 3) begin
        a = $urandom;
        if (a[31:16] == 16'hFFFF) a[31] = 1'b0;
        a[1:0] = 2'b00;
        wd = $urandom;
      end else begin
        a = {16'hFFFF, offs[$urandom_range(0, 6)]};
        if (a[15:0] == 16'h0004 || a[15:0] == 16'h0008) begin
          wd = 32'($urandom_range(0, 12));
        end else begin
          wd = $urandom;
          wd[0] = ($urandom_range(0, 3) != 0);
        end
      end
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      drive(mw, a, wd);
      exp_rd = m_read(a, known);
      if (known) check($sformatf("rnd%0d_rd", n), readdata, exp_rd);
      m_clock(mw, a, wd);
      step;
      check($sformatf("rnd%0d_gpio", n), {24'd0, gpio_out}, {24'd0, m_gpio});
      check($sformatf("rnd%0d_irq", n), {31'd0, timer_irq}, {31'd0, m_match});
      check($sformatf("rnd%0d_err", n), {31'd0, err_flag}, (m_err != 0) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
